// File: rtl/alu16.sv
// ============================================================================
// Module   : alu16
// Summary  : Registered WIDTH-bit ALU (ADD/SUB/AND/OR) with carry and flags.
//            Optional macro ALU_SAT_EN enables signed saturation on ADD/SUB.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             out_valid
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  logic [WIDTH-1:0] b_eff;
  logic             carry_in;
  logic [WIDTH:0]   sum;
  logic             is_arith;
  logic             ovf_c;
  logic             cout_c;
  logic [WIDTH-1:0] res_c;

  // SUB reuses the adder as i0 + ~i1 + 1
  always_comb begin
    b_eff    = i1;
    carry_in = 1'b0;
    if (op == OP_SUB) begin
      b_eff    = ~i1;
      carry_in = 1'b1;
    end
  end

  assign sum      = {1'b0, i0} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);

  always_comb begin
    res_c  = i0 | i1;
    cout_c = 1'b0;
    ovf_c  = 1'b0;
    if (is_arith) begin
      res_c  = sum[WIDTH-1:0];
      cout_c = sum[WIDTH];
      // Same-sign operands into the adder producing a different sign
      ovf_c  = (i0[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != i0[WIDTH-1]);
`ifdef ALU_SAT_EN
      if (ovf_c) begin
        res_c = sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      end
`endif
    end else if (op == OP_AND) begin
      res_c = i0 & i1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o         <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        o    <= res_c;
        cout <= cout_c;
        zero <= (res_c == '0);
        neg  <= res_c[WIDTH-1];
        ovf  <= ovf_c;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu16.sv
// ============================================================================
// Module   : tb_alu16
// Summary  : Directed self-checking bench for alu16.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu16;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] o;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             out_valid;

  int checks = 0;
  int errors = 0;

  alu16 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .i0        (i0),
    .i1        (i1),
    .o         (o),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: {o, cout, zero, neg, ovf, out_valid}
  task automatic check(input string tag, input logic [WIDTH-1:0] e_o, input logic e_c,
                       input logic e_z, input logic e_n, input logic e_v, input logic e_ov);
    logic [WIDTH+4:0] obs;
    logic [WIDTH+4:0] exp;
    obs = {o, cout, zero, neg, ovf, out_valid};
    exp = {e_o, e_c, e_z, e_n, e_v, e_ov};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed o=%h c=%b z=%b n=%b v=%b ov=%b expected o=%h c=%b z=%b n=%b v=%b ov=%b",
             tag, o, cout, zero, neg, ovf, out_valid, e_o, e_c, e_z, e_n, e_v, e_ov);
    end
  endtask

  task automatic drive(input logic [1:0] o_p, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o_p;
    i0       = a;
    i1       = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b1;
    op       = 2'b01;
    i0       = 16'h1234;
    i1       = 16'habcd;

    // Reset held with garbage ops presented
    #2;
    check("reset_initial", 16'h0000, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", 16'h0000, 0, 0, 0, 0, 0);

    @(negedge clk);
    reset = 1'b1;
    drive(2'b00, 16'h0000, 16'h0000);
    check("add_0_0", 16'h0000, 0, 1, 0, 0, 1);

    drive(2'b00, 16'haa55, 16'h55aa);
    check("add_aa55_55aa", 16'hffff, 0, 0, 1, 0, 1);
    drive(2'b00, 16'hffff, 16'h0001);
    check("add_ffff_0001", 16'h0000, 1, 1, 0, 0, 1);
    drive(2'b00, 16'h0001, 16'h7fff);
`ifdef ALU_SAT_EN
    check("add_0001_7fff", 16'h7fff, 0, 0, 0, 1, 1);
`else
    check("add_0001_7fff", 16'h8000, 0, 0, 1, 1, 1);
`endif

    drive(2'b01, 16'haa55, 16'h55aa);
`ifdef ALU_SAT_EN
    check("sub_aa55_55aa", 16'h8000, 1, 0, 1, 1, 1);
`else
    check("sub_aa55_55aa", 16'h54ab, 1, 0, 0, 1, 1);
`endif
    drive(2'b01, 16'hffff, 16'h0001);
    check("sub_ffff_0001", 16'hfffe, 1, 0, 1, 0, 1);
    drive(2'b01, 16'h0001, 16'h7fff);
    check("sub_0001_7fff", 16'h8002, 0, 0, 1, 0, 1);
    drive(2'b01, 16'h0000, 16'h0000);
    check("sub_0_0", 16'h0000, 1, 1, 0, 0, 1);

    drive(2'b10, 16'haa55, 16'h55aa);
    check("and_aa55_55aa", 16'h0000, 0, 1, 0, 0, 1);
    drive(2'b10, 16'hffff, 16'h0001);
    check("and_ffff_0001", 16'h0001, 0, 0, 0, 0, 1);
    drive(2'b11, 16'haa55, 16'h55aa);
    check("or_aa55_55aa", 16'hffff, 0, 0, 1, 0, 1);
    drive(2'b11, 16'h0001, 16'h7fff);
    check("or_0001_7fff", 16'h7fff, 0, 0, 0, 0, 1);

    // Idle cycles: result held, out_valid drops; operands changed to prove no capture
    @(negedge clk);
    in_valid = 1'b0;
    op       = 2'b00;
    i0       = 16'hffff;
    i1       = 16'h0001;
    @(posedge clk); #1;
    check("idle_hold_1", 16'h7fff, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("idle_hold_2", 16'h7fff, 0, 0, 0, 0, 0);

    // Back-to-back after idle: carry out and zero set from a valid ADD
    drive(2'b00, 16'hffff, 16'h0001);
    check("b2b_add", 16'h0000, 1, 1, 0, 0, 1);
    drive(2'b01, 16'h0001, 16'h7fff);
    check("b2b_sub", 16'h8002, 0, 0, 1, 0, 1);

    // Asynchronous reset between edges while out_valid=1
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_clear", 16'h0000, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("reset_discards_op", 16'h0000, 0, 0, 0, 0, 0);

    @(negedge clk);
    reset = 1'b1;
    drive(2'b11, 16'h0001, 16'h7fff);
    check("post_reset_or", 16'h7fff, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu16.md
Name: alu16

Overview:
- Registered WIDTH-bit (default 16) integer ALU: ADD, SUB, AND, OR selected by a 2-bit opcode.
- Produces result, carry-out and status flags.
- Sits behind operand-select logic in the datapath; one-cycle latency with a simple valid strobe.

Parameters:
- WIDTH, 16, operand/result width in bits (minimum 2).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  input  1  operands/op valid this cycle
- op  input  2  operation: 00 ADD, 01 SUB, 10 AND, 11 OR
- i0  input  WIDTH  operand A
- i1  input  WIDTH  operand B
- o  output  WIDTH  registered result
- cout  output  1  registered carry-out
- zero  output  1  registered: o == 0
- neg  output  1  registered: o[WIDTH-1]
- ovf  output  1  registered signed overflow
- out_valid  output  1  registered: outputs hold a new result

Behaviour:
- Reset (reset low, asynchronous): o=0, cout=0, zero=0, neg=0, ovf=0, out_valid=0. These values are held while reset is low. The first capture happens on the first rising edge after reset is released.
- Capture: on a rising edge with in_valid=1, the combinational result is registered into o, cout and the flags, and out_valid=1. Latency is one cycle, and a new op is accepted every cycle with no stall.
- Hold: on a rising edge with in_valid=0, o, cout and the flags hold their values and out_valid=0.
- ADD (00):
  - {cout,o} = i0 + i1 at WIDTH+1 bits; the result wraps modulo 2^WIDTH.
  - ovf = 1 when i0 and i1 have the same sign bit and o's sign bit differs from it.
- SUB (01):
  - {cout,o} = i0 + ~i1 + 1 at WIDTH+1 bits.
  - cout=1 means no borrow (i0 >= i1 unsigned).
  - ovf = 1 when i0 and i1 have different sign bits and o's sign bit differs from i0's.
- AND (10): o = i0 & i1; cout=0; ovf=0.
- OR (11): o = i0 | i1; cout=0; ovf=0.
- Flags for every op: zero = (o == 0) and neg = o[WIDTH-1], both computed on the final registered o.
- An op value that is X or Z is treated as OR; the bench does not rely on this.
- Reset asserted mid-stream: outputs clear immediately, without waiting for a clock edge. An op presented in the same cycle as reset is discarded.

Optional Feature:
- Macro: ALU_SAT_EN.
- When defined, ADD and SUB saturate in signed arithmetic whenever ovf=1:
  - positive overflow gives o = 0x7FFF (2^(WIDTH-1)-1);
  - negative overflow gives o = 0x8000 (-2^(WIDTH-1)).
- cout and ovf still report the unsaturated computation; zero and neg reflect the saturated o.
- When undefined, ADD and SUB wrap modulo 2^WIDTH as described above. AND and OR are unaffected either way.

Test Plan:
- Reset: drive reset=0 while in_valid=1 with garbage operands -> all outputs 0, out_valid=0. Release reset, then ADD 0000+0000 -> next cycle o=0000, cout=0, zero=1, out_valid=1.
- ADD:
  - aa55+55aa -> o=ffff, cout=0, neg=1, ovf=0.
  - ffff+0001 -> o=0000, cout=1, zero=1.
  - 0001+7fff -> o=8000, cout=0, ovf=1, neg=1 (with ALU_SAT_EN: o=7fff, neg=0).
- SUB:
  - aa55-55aa -> o=54ab, cout=1, ovf=1 (with ALU_SAT_EN: o=8000).
  - ffff-0001 -> o=fffe, cout=1, ovf=0.
  - 0001-7fff -> o=8002, cout=0, neg=1, ovf=0.
  - 0000-0000 -> o=0000, cout=1, zero=1.
- AND/OR:
  - aa55&55aa -> 0000, zero=1.
  - ffff&0001 -> 0001.
  - aa55|55aa -> ffff.
  - 0001|7fff -> 7fff.
  - cout=0 and ovf=0 for all four.
- Back-to-back ops each cycle, then one cycle with in_valid=0 -> each result appears exactly one cycle after its op. During the idle cycle o holds the last value and out_valid=0.
- Reset asserted asynchronously between clock edges while out_valid=1 -> outputs clear before the next rising edge.
